// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operation selects and the bundled control-strobe struct.
package cu_pkg;

   // Opcodes are 3-bit codes, zero-extended to the opcode width of the unit.
   localparam logic [2:0] OP_LW   = 3'd1;
   localparam logic [2:0] OP_SW   = 3'd2;
   localparam logic [2:0] OP_J    = 3'd3;
   localparam logic [2:0] OP_ADD  = 3'd4;
   localparam logic [2:0] OP_ADDI = 3'd5;
   localparam logic [2:0] OP_SUB  = 3'd6;
   localparam logic [2:0] OP_BEQ  = 3'd7;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       jump;
      logic       branch;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       illegal_op;
      logic       mem_err;
      logic       busy;
   } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory accesses: clears on request, counts cycles
// without mem_ready and saturates at MEM_TIMEOUT, where expired goes high.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMR_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);

   logic [TMR_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q <= '0;
      end else if (enable && (cnt_q != LIMIT)) begin
         cnt_q <= cnt_q + TMR_W'(1);
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Build option: define BRANCH_EQ_EN to decode opcode 7 as BEQ (otherwise it is illegal).
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int OPCODE_W    = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int TMR_W       = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                pc_write,
   output logic                jump,
   output logic                branch,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                alu_src,
   output logic [1:0]          alu_op,
   output logic                reg_write,
   output logic                illegal_op,
   output logic                mem_err,
   output logic                busy
);

   // Memory handshake: mem_read/mem_write stay high for the whole FETCH/MEM
   // state; the access completes in any cycle where mem_ready is 1, and the
   // request is abandoned after MEM_TIMEOUT wait cycles without mem_ready.

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [OPCODE_W-1:0] op_cur;
   logic                waiting, timeout;
   logic                tmr_clear, tmr_en, tmr_expired;
   logic                is_lw, is_sw, is_j, is_add, is_addi, is_sub, is_beq, legal;
   ctrl_t               ctrl;

   function automatic logic op_is(input logic [OPCODE_W-1:0] op, input logic [2:0] code);
      return op == OPCODE_W'(code);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
      end
   end

   // IR is loaded at the end of FETCH, so DECODE reads the live field while
   // it is being latched; later states use the latched copy.
   assign op_cur = (state_q == S_DECODE) ? opcode : op_q;

   assign is_lw   = op_is(op_cur, OP_LW);
   assign is_sw   = op_is(op_cur, OP_SW);
   assign is_j    = op_is(op_cur, OP_J);
   assign is_add  = op_is(op_cur, OP_ADD);
   assign is_addi = op_is(op_cur, OP_ADDI);
   assign is_sub  = op_is(op_cur, OP_SUB);
`ifdef BRANCH_EQ_EN
   assign is_beq  = op_is(op_cur, OP_BEQ);
`else
   assign is_beq  = 1'b0;
`endif
   assign legal = is_lw | is_sw | is_j | is_add | is_addi | is_sub | is_beq;

   assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
   assign timeout   = waiting && tmr_expired && !mem_ready;
   assign tmr_en    = waiting && !mem_ready;
   // A FETCH timeout re-enters FETCH without a state change, so clear explicitly.
   assign tmr_clear = (state_d != state_q) || timeout;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TMR_W       (TMR_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_j || !legal) state_d = S_FETCH;
            else                state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_lw || is_sw)                    state_d = S_MEM;
            else if (is_add || is_sub || is_addi)  state_d = S_WB;
            else                                   state_d = S_FETCH;
         end
         S_MEM: begin
            if (mem_ready && is_lw)            state_d = S_WB;
            else if (mem_ready || timeout)     state_d = S_FETCH;
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      ctrl      = '0;
      ctrl.busy = (state_q != S_IDLE);
      case (state_q)
         S_FETCH: begin
            ctrl.iord     = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.ir_write = mem_ready;
            ctrl.pc_write = mem_ready;
            ctrl.mem_err  = timeout;
         end
         S_DECODE: begin
            if (is_j) begin
               ctrl.pc_write = 1'b1;
               ctrl.jump     = 1'b1;
            end else if (!legal) begin
               ctrl.illegal_op = 1'b1;
            end
         end
         S_EXEC: begin
            if (is_lw || is_sw) begin
               ctrl.alu_src = 1'b1;
               ctrl.alu_op  = ALU_ADD;
            end else if (is_add || is_sub) begin
               ctrl.alu_op  = ALU_FUNCT;
            end else if (is_addi) begin
               ctrl.alu_op  = ALU_FUNCT;
               ctrl.alu_src = 1'b1;
            end else if (is_beq) begin
               // PC update is gated by ALU zero in the datapath.
               ctrl.alu_op   = ALU_SUB;
               ctrl.branch   = 1'b1;
               ctrl.pc_write = 1'b1;
            end
         end
         S_MEM: begin
            ctrl.mem_read  = is_lw;
            ctrl.mem_write = is_sw;
            ctrl.mem_err   = timeout;
         end
         S_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = is_add | is_sub;
            ctrl.mem_to_reg = is_lw;
         end
         default: begin
         end
      endcase
      // Reset aborts at once: nothing, not even busy, is driven in that cycle.
      if (reset) ctrl = '0;
   end

   assign iord       = ctrl.iord;
   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign ir_write   = ctrl.ir_write;
   assign pc_write   = ctrl.pc_write;
   assign jump       = ctrl.jump;
   assign branch     = ctrl.branch;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src    = ctrl.alu_src;
   assign alu_op     = ctrl.alu_op;
   assign reg_write  = ctrl.reg_write;
   assign illegal_op = ctrl.illegal_op;
   assign mem_err    = ctrl.mem_err;
   assign busy       = ctrl.busy;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle vector bench for multicycle_control_unit (default build, BEQ disabled).
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [2:0]  opcode = 3'd0;
   logic        mem_ready = 1'b0;
   logic        iord, mem_read, mem_write, ir_write, pc_write, jump, branch;
   logic        reg_dst, mem_to_reg, alu_src, reg_write, illegal_op, mem_err, busy;
   logic [1:0]  alu_op;
   logic [15:0] outs;

   int vectors = 0;
   int miscompares = 0;

   // Expected-output bit masks.
   localparam logic [15:0] O_IORD  = 16'h8000;
   localparam logic [15:0] O_MRD   = 16'h4000;
   localparam logic [15:0] O_MWR   = 16'h2000;
   localparam logic [15:0] O_IRW   = 16'h1000;
   localparam logic [15:0] O_PCW   = 16'h0800;
   localparam logic [15:0] O_JMP   = 16'h0400;
   localparam logic [15:0] O_RDST  = 16'h0100;
   localparam logic [15:0] O_M2R   = 16'h0080;
   localparam logic [15:0] O_ASRC  = 16'h0040;
   localparam logic [15:0] O_FUNCT = 16'h0020;
   localparam logic [15:0] O_RW    = 16'h0008;
   localparam logic [15:0] O_ILL   = 16'h0004;
   localparam logic [15:0] O_MERR  = 16'h0002;
   localparam logic [15:0] O_BUSY  = 16'h0001;

   localparam logic [15:0] E_IDLE    = 16'h0000;
   localparam logic [15:0] E_FETCH_W = O_IORD | O_MRD | O_BUSY;
   localparam logic [15:0] E_FETCH_R = O_IORD | O_MRD | O_IRW | O_PCW | O_BUSY;
   localparam logic [15:0] E_DEC     = O_BUSY;
   localparam logic [15:0] E_DEC_J   = O_PCW | O_JMP | O_BUSY;
   localparam logic [15:0] E_DEC_ILL = O_ILL | O_BUSY;
   localparam logic [15:0] E_EX_MEM  = O_ASRC | O_BUSY;
   localparam logic [15:0] E_EX_R    = O_FUNCT | O_BUSY;
   localparam logic [15:0] E_EX_I    = O_FUNCT | O_ASRC | O_BUSY;
   localparam logic [15:0] E_MEM_LW  = O_MRD | O_BUSY;
   localparam logic [15:0] E_MEM_SW  = O_MWR | O_BUSY;
   localparam logic [15:0] E_WB_R    = O_RW | O_RDST | O_BUSY;
   localparam logic [15:0] E_WB_LW   = O_RW | O_M2R | O_BUSY;
   localparam logic [15:0] E_WB_I    = O_RW | O_BUSY;

   typedef struct {
      logic        rst;
      logic        run;
      logic [2:0]  op;
      logic        rdy;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[$];

   multicycle_control_unit dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .jump       (jump),
      .branch     (branch),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .reg_write  (reg_write),
      .illegal_op (illegal_op),
      .mem_err    (mem_err),
      .busy       (busy)
   );

   assign outs = {iord, mem_read, mem_write, ir_write, pc_write, jump, branch, reg_dst,
                  mem_to_reg, alu_src, alu_op, reg_write, illegal_op, mem_err, busy};

   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic rn, input logic [2:0] op,
                               input logic rdy, input logic [15:0] exp);
      tbl.push_back('{rst: r, run: rn, op: op, rdy: rdy, exp: exp});
   endfunction

   // One clock cycle: drive just after the rising edge, compare at the falling edge.
   task automatic step(input logic r, input logic rn, input logic [2:0] op, input logic rdy,
                       input logic [15:0] exp, input string name);
      @(posedge clk);
      #1;
      reset     = r;
      run       = rn;
      opcode    = op;
      mem_ready = rdy;
      @(negedge clk);
      vectors++;
      if (outs !== exp) begin
         miscompares++;
         $display("FAIL %s: outputs %h, expected %h", name, outs, exp);
      end
   endtask

   initial begin
      // rst run op rdy expected
      add(1, 0, 3'd0, 0, E_IDLE);       // reset cycle
      add(0, 0, 3'd0, 0, E_IDLE);
      add(0, 0, 3'd0, 1, E_IDLE);       // mem_ready ignored in IDLE
      add(0, 1, 3'd4, 1, E_IDLE);       // run sampled, FETCH next
      add(0, 1, 3'd4, 1, E_FETCH_R);    // ADD
      add(0, 1, 3'd4, 1, E_DEC);
      add(0, 1, 3'd4, 1, E_EX_R);
      add(0, 1, 3'd4, 1, E_WB_R);
      add(0, 1, 3'd5, 1, E_FETCH_R);    // ADDI
      add(0, 1, 3'd5, 1, E_DEC);
      add(0, 1, 3'd5, 1, E_EX_I);
      add(0, 1, 3'd5, 1, E_WB_I);
      add(0, 0, 3'd6, 1, E_FETCH_R);    // SUB, run low is ignored
      add(0, 0, 3'd6, 1, E_DEC);
      add(0, 0, 3'd6, 1, E_EX_R);
      add(0, 0, 3'd6, 1, E_WB_R);
      add(0, 0, 3'd3, 1, E_FETCH_R);    // J
      add(0, 0, 3'd3, 1, E_DEC_J);
      add(0, 0, 3'd0, 0, E_FETCH_W);    // opcode 0, one wait in FETCH
      add(0, 0, 3'd0, 1, E_FETCH_R);
      add(0, 0, 3'd0, 1, E_DEC_ILL);
      add(0, 0, 3'd7, 1, E_FETCH_R);    // opcode 7 illegal without BEQ
      add(0, 0, 3'd7, 1, E_DEC_ILL);
      add(0, 0, 3'd1, 1, E_FETCH_R);    // LW with 3 wait cycles in MEM
      add(0, 0, 3'd1, 1, E_DEC);
      add(0, 0, 3'd1, 0, E_EX_MEM);
      add(0, 0, 3'd1, 0, E_MEM_LW);
      add(0, 0, 3'd1, 0, E_MEM_LW);
      add(0, 0, 3'd1, 0, E_MEM_LW);
      add(0, 0, 3'd1, 1, E_MEM_LW);
      add(0, 0, 3'd1, 0, E_WB_LW);
      add(0, 0, 3'd2, 1, E_FETCH_R);    // SW, zero wait
      add(0, 0, 3'd2, 1, E_DEC);
      add(0, 0, 3'd2, 1, E_EX_MEM);
      add(0, 0, 3'd2, 1, E_MEM_SW);
      add(0, 0, 3'd1, 1, E_FETCH_R);    // LW aborted by reset in MEM
      add(0, 0, 3'd1, 1, E_DEC);
      add(0, 0, 3'd1, 0, E_EX_MEM);
      add(0, 0, 3'd1, 0, E_MEM_LW);
      add(1, 0, 3'd1, 1, E_IDLE);
      add(0, 0, 3'd1, 1, E_IDLE);       // back in IDLE, no WB
      add(0, 0, 3'd1, 1, E_IDLE);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].run, tbl[i].op, tbl[i].rdy, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // SW whose memory never answers: mem_err on the 16th MEM cycle.
      step(1, 0, 3'd2, 0, E_IDLE, "sw_to_reset");
      step(0, 1, 3'd2, 1, E_IDLE, "sw_to_idle");
      step(0, 0, 3'd2, 1, E_FETCH_R, "sw_to_fetch");
      step(0, 0, 3'd2, 0, E_DEC, "sw_to_decode");
      step(0, 0, 3'd2, 0, E_EX_MEM, "sw_to_exec");
      for (int i = 0; i < 15; i++) begin
         step(0, 0, 3'd2, 0, E_MEM_SW, $sformatf("sw_to_wait%0d", i));
      end
      step(0, 0, 3'd2, 0, E_MEM_SW | O_MERR, "sw_to_err");

      // Back in FETCH: memory silent again, fetch times out as well.
      for (int i = 0; i < 15; i++) begin
         step(0, 0, 3'd4, 0, E_FETCH_W, $sformatf("if_to_wait%0d", i));
      end
      step(0, 0, 3'd4, 0, E_FETCH_W | O_MERR, "if_to_err");

      // Re-entered FETCH with a fresh count; ready on the limit cycle wins.
      for (int i = 0; i < 15; i++) begin
         step(0, 0, 3'd4, 0, E_FETCH_W, $sformatf("if_edge_wait%0d", i));
      end
      step(0, 0, 3'd4, 1, E_FETCH_R, "if_edge_ready");
      step(0, 0, 3'd4, 1, E_DEC, "if_edge_decode");
      step(0, 0, 3'd4, 1, E_EX_R, "if_edge_exec");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
